me_mv_buffer: RTL

Downstream stage of the high-bandwidth motion-estimation core. Captures each per-macroblock best match (MSAD, row, column, data_valid), converts the window position to a signed motion vector, and tags it with the macroblock coordinate in the frame. Buffers results in a small FIFO and presents them to the entropy-coding stage over a valid/ready handshake. The ME core has no backpressure input, so the block also detects and flags result loss.

---
 rtl/me_pkg.sv | 36 +++
 rtl/me_mv_fifo.sv | 76 +++++++
 rtl/me_mv_buffer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/me_pkg.sv
// ---------------------------------------------------------------------------
// me_pkg - shared types and constants for the motion-estimation result path.
//
// Contents:
//   SAD_W, POS_W, MV_W     field widths (SAD, window position, motion vector)
//   MB_COLS_DEF/ROWS_DEF   default frame size in macroblocks (CIF)
//   MB_X_W, MB_Y_W         coordinate field widths sized from the defaults
//   mv_entry_t             one buffered result {mb_x, mb_y, mv_y, mv_x, sad, intra}
//
// Optional macro: ME_MV_INTRA_EN adds the intra flag bit to mv_entry_t.
// Without it the struct carries no intra storage at all.
// ---------------------------------------------------------------------------
package me_pkg;

  localparam int SAD_W = 14;
  localparam int POS_W = 5;
  localparam int MV_W  = 6;

  localparam int MB_COLS_DEF = 22;
  localparam int MB_ROWS_DEF = 18;

  localparam int MB_X_W = $clog2(MB_COLS_DEF);
  localparam int MB_Y_W = $clog2(MB_ROWS_DEF);

  typedef struct packed {
    logic [MB_X_W-1:0] mb_x;
    logic [MB_Y_W-1:0] mb_y;
    logic [MV_W-1:0]   mv_y;
    logic [MV_W-1:0]   mv_x;
    logic [SAD_W-1:0]  sad;
`ifdef ME_MV_INTRA_EN
    logic              intra;
`endif
  } mv_entry_t;

endpackage

// File: rtl/me_mv_fifo.sv
// ---------------------------------------------------------------------------
// me_mv_fifo - DEPTH x mv_entry_t synchronous FIFO with fall-through head.
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-low reset
//   push   in   write request (accepted when not full, or full with a pop)
//   pop    in   read request (ignored when empty)
//   din    in   entry to write
//   dout   out  head entry, all-zero while empty
//   full   out  DEPTH entries held
//   empty  out  no entries held
//   level  out  occupancy 0..DEPTH
//
// Storage is registered; the head is read combinationally so a push at edge
// N is visible on dout right after that edge.
// ---------------------------------------------------------------------------
module me_mv_fifo
  import me_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  mv_entry_t              din,
  output mv_entry_t              dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  mv_entry_t         mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [AW:0]       count_reg;
  logic              do_pop;
  logic              do_push;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign level   = count_reg;
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push && (!full || do_pop);

  // Zero the head while empty so the output fields read as 0 after reset.
  assign dout = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/me_mv_buffer.sv
// ---------------------------------------------------------------------------
// me_mv_buffer - captures per-macroblock best matches from the ME core,
// converts window position to a signed motion vector, tags it with the
// macroblock coordinate and queues it for the entropy coder (valid/ready).
//
// Ports:
//   clk, rst                 clock; synchronous active-low reset
//   MSAD, MSAD_row,
//   MSAD_column, data_valid  best-match result strobe from the ME core
//   mv_valid, mv_ready       output handshake
//   mv_x, mv_y               signed vector (position - MV_OFFSET)
//   mv_sad, mv_intra         SAD of the entry, intra flag
//   mv_mb_x, mv_mb_y         macroblock coordinate of the entry
//   frame_done               pulse after the last macroblock of a frame
//   overflow                 sticky: a result was dropped on a full FIFO
//   level                    FIFO occupancy
//
// Optional macro: ME_MV_INTRA_EN enables the SAD > SAD_THRESH intra flag.
// Without it there is no comparator and mv_intra is tied to 0.
// ---------------------------------------------------------------------------
module me_mv_buffer
  import me_pkg::*;
#(
  parameter int               MB_COLS    = MB_COLS_DEF,
  parameter int               MB_ROWS    = MB_ROWS_DEF,
  parameter int               MV_OFFSET  = 16,
  parameter int               DEPTH      = 8,
  parameter logic [SAD_W-1:0] SAD_THRESH = 14'd2048
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [SAD_W-1:0]           MSAD,
  input  logic [POS_W-1:0]           MSAD_row,
  input  logic [POS_W-1:0]           MSAD_column,
  input  logic                       data_valid,
  output logic                       mv_valid,
  input  logic                       mv_ready,
  output logic [MV_W-1:0]            mv_x,
  output logic [MV_W-1:0]            mv_y,
  output logic [SAD_W-1:0]           mv_sad,
  output logic                       mv_intra,
  output logic [$clog2(MB_COLS)-1:0] mv_mb_x,
  output logic [$clog2(MB_ROWS)-1:0] mv_mb_y,
  output logic                       frame_done,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int MBX_W = $clog2(MB_COLS);
  localparam int MBY_W = $clog2(MB_ROWS);

  logic [MBX_W-1:0] mb_x_reg;
  logic [MBY_W-1:0] mb_y_reg;
  logic             frame_done_reg;
  logic             overflow_reg;

  mv_entry_t        entry_in;
  mv_entry_t        head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             last_col;
  logic             last_row;

  assign last_col = (mb_x_reg == MBX_W'(MB_COLS - 1));
  assign last_row = (mb_y_reg == MBY_W'(MB_ROWS - 1));
  assign pop      = mv_valid && mv_ready;

  // Vector conversion: zero-extend the window position and subtract the
  // centre offset in MV_W bits; wrap-around is the intended truncation.
  always_comb begin
    entry_in      = '0;
    entry_in.mb_x = MB_X_W'(mb_x_reg);
    entry_in.mb_y = MB_Y_W'(mb_y_reg);
    entry_in.mv_x = {1'b0, MSAD_column} - MV_W'(MV_OFFSET);
    entry_in.mv_y = {1'b0, MSAD_row}    - MV_W'(MV_OFFSET);
    entry_in.sad  = MSAD;
`ifdef ME_MV_INTRA_EN
    entry_in.intra = (MSAD > SAD_THRESH);
`endif
  end

  me_mv_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (data_valid),
    .pop   (pop),
    .din   (entry_in),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign mv_valid = !fifo_empty;
  assign mv_x     = head.mv_x;
  assign mv_y     = head.mv_y;
  assign mv_sad   = head.sad;
  assign mv_mb_x  = MBX_W'(head.mb_x);
  assign mv_mb_y  = MBY_W'(head.mb_y);
`ifdef ME_MV_INTRA_EN
  assign mv_intra = head.intra;
`else
  assign mv_intra = 1'b0;
`endif

  // The position counter tracks every result the core produces, stored or
  // dropped, so coordinates stay aligned with the frame after a loss.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mb_x_reg       <= '0;
      mb_y_reg       <= '0;
      frame_done_reg <= 1'b0;
      overflow_reg   <= 1'b0;
    end else begin
      frame_done_reg <= data_valid && last_col && last_row;
      if (data_valid) begin
        if (last_col) begin
          mb_x_reg <= '0;
          mb_y_reg <= last_row ? '0 : mb_y_reg + 1'b1;
        end else begin
          mb_x_reg <= mb_x_reg + 1'b1;
        end
      end
      if (data_valid && fifo_full && !pop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign frame_done = frame_done_reg;
  assign overflow   = overflow_reg;

endmodule
